// File: rtl/hd44780_pkg.sv
// Shared types and constants for the HD44780 power-on init sequencer.
// FSET selection between the two variants is made by HD44780_TWO_LINE_EN.
package hd44780_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_POR,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_RUN
    } state_t;

    localparam logic [7:0] CMD_WAKE     = 8'h30;
    localparam logic [7:0] CMD_FSET_1L  = 8'h30;
    localparam logic [7:0] CMD_FSET_2L  = 8'h38;
    localparam logic [7:0] CMD_DISP_OFF = 8'h08;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;

    // A zero-length wait still occupies one tick; oversize waits saturate.
    function automatic logic [CNT_W-1:0] wait_len(input int unsigned w);
        if (w == 0)
            return 16'd1;
        else if (w > 32'd65535)
            return 16'hFFFF;
        else
            return w[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/hd44780_init_sequencer_if.sv
// LCD-style 8-bit bus bundle (register select, enable strobe, data byte).
interface hd44780_init_sequencer_if;
    logic       rs;
    logic       e;
    logic [7:0] d;

    modport master (output rs, output e, output d);
    modport slave  (input  rs, input  e, input  d);
endinterface

// File: rtl/hd44780_init_rom.sv
// Init command table: index -> command byte plus long-wait flag.
// Define HD44780_TWO_LINE_EN to select the 2-line function-set byte.
module hd44780_init_rom
    import hd44780_pkg::*;
(
    input  logic [2:0] i_idx,
    output logic [7:0] o_cmd,
    output logic       o_long
);

`ifdef HD44780_TWO_LINE_EN
    localparam logic [7:0] FSET = CMD_FSET_2L;
`else
    localparam logic [7:0] FSET = CMD_FSET_1L;
`endif

    always_comb begin
        o_cmd = CMD_WAKE;
        case (i_idx)
            3'd0:    o_cmd = CMD_WAKE;
            3'd1:    o_cmd = CMD_WAKE;
            3'd2:    o_cmd = CMD_WAKE;
            3'd3:    o_cmd = FSET;
            3'd4:    o_cmd = CMD_DISP_OFF;
            3'd5:    o_cmd = CMD_CLEAR;
            3'd6:    o_cmd = CMD_ENTRY;
            default: o_cmd = CMD_DISP_ON;
        endcase
    end

    assign o_long = (o_cmd == CMD_CLEAR);

endmodule

// File: rtl/hd44780_init_sequencer.sv
// HD44780 power-on init sequencer; hands the bus to a runtime writer once done.
// Build option: HD44780_TWO_LINE_EN (2-line function set, see hd44780_init_rom).
module hd44780_init_sequencer
    import hd44780_pkg::*;
#(
    parameter int POR_WAIT = 16000,
    parameter int CMD_WAIT = 50,
    parameter int CLR_WAIT = 2000,
    parameter int E_WIDTH  = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ena,
    input  logic       i_reinit,
    input  logic       i_run_rs,
    input  logic       i_run_e,
    input  logic [7:0] i_run_d,
    output logic       o_rs,
    output logic       o_e,
    output logic [7:0] o_d,
    output logic       o_ready,
    output logic       o_run_reset
);

    localparam logic [CNT_W-1:0] T_POR = wait_len(POR_WAIT);
    localparam logic [CNT_W-1:0] T_CMD = wait_len(CMD_WAIT);
    localparam logic [CNT_W-1:0] T_CLR = wait_len(CLR_WAIT);
    localparam logic [CNT_W-1:0] T_EW  = wait_len(E_WIDTH);

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_long;
    logic             r_rs;
    logic             r_e;
    logic [7:0]       r_d;
    logic             r_ready;
    logic             r_run_reset;

    logic [2:0]       w_addr;
    logic [7:0]       w_cmd;
    logic             w_long;
    logic [CNT_W-1:0] w_target;
    logic             w_done;
    logic             w_run;

    // In S_WAIT the ROM looks one entry ahead so S_SETUP is entered with its byte.
    always_comb begin
        w_addr = r_idx;
        if (r_state == S_WAIT)
            w_addr = r_idx + 3'd1;
        else if (r_state == S_POR || r_state == S_RUN)
            w_addr = 3'd0;
    end

    hd44780_init_rom u_rom (
        .i_idx  (w_addr),
        .o_cmd  (w_cmd),
        .o_long (w_long)
    );

    always_comb begin
        w_target = 16'd1;
        case (r_state)
            S_POR:   w_target = T_POR;
            S_SETUP: w_target = 16'd1;
            S_PULSE: w_target = T_EW;
            S_WAIT:  w_target = r_long ? T_CLR : T_CMD;
            default: w_target = 16'd1;
        endcase
    end

    // r_cnt counts elapsed ticks in the current state, so it never exceeds target-1.
    assign w_done = (r_cnt >= (w_target - 16'd1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_POR;
            r_idx       <= 3'd0;
            r_cnt       <= '0;
            r_long      <= 1'b0;
            r_rs        <= 1'b0;
            r_e         <= 1'b0;
            r_d         <= 8'h00;
            r_ready     <= 1'b0;
            r_run_reset <= 1'b1;
        end else if (r_state == S_RUN) begin
            if (i_reinit) begin
                r_state     <= S_SETUP;
                r_idx       <= 3'd0;
                r_cnt       <= '0;
                r_rs        <= 1'b0;
                r_e         <= 1'b0;
                r_d         <= w_cmd;
                r_ready     <= 1'b0;
                r_run_reset <= 1'b1;
            end
        end else if (i_ena) begin
            if (!w_done) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
                case (r_state)
                    S_POR: begin
                        r_state <= S_SETUP;
                        r_idx   <= 3'd0;
                        r_rs    <= 1'b0;
                        r_e     <= 1'b0;
                        r_d     <= w_cmd;
                    end
                    S_SETUP: begin
                        r_state <= S_PULSE;
                        r_e     <= 1'b1;
                    end
                    S_PULSE: begin
                        r_state <= S_WAIT;
                        r_e     <= 1'b0;
                        r_long  <= w_long;
                    end
                    S_WAIT: begin
                        if (r_idx == 3'd7) begin
                            r_state     <= S_RUN;
                            r_ready     <= 1'b1;
                            r_run_reset <= 1'b0;
                        end else begin
                            r_state <= S_SETUP;
                            r_idx   <= r_idx + 3'd1;
                            r_d     <= w_cmd;
                        end
                    end
                    default: r_state <= S_POR;
                endcase
            end
        end
    end

    assign w_run       = (r_state == S_RUN);
    assign o_rs        = w_run ? i_run_rs : r_rs;
    assign o_e         = w_run ? i_run_e  : r_e;
    assign o_d         = w_run ? i_run_d  : r_d;
    assign o_ready     = r_ready;
    assign o_run_reset = r_run_reset;

endmodule

// File: tb/tb_hd44780_init_sequencer.sv
// Directed self-checking bench for hd44780_init_sequencer (short wait parameters).
module tb_hd44780_init_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       reinit;
    logic       ready;
    logic       run_reset;
    int         n_total = 0;
    int         n_bad   = 0;

    hd44780_init_sequencer_if run_bus ();
    hd44780_init_sequencer_if lcd_bus ();

    hd44780_init_sequencer #(
        .POR_WAIT (4),
        .CMD_WAIT (2),
        .CLR_WAIT (5),
        .E_WIDTH  (1)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_ena       (ena),
        .i_reinit    (reinit),
        .i_run_rs    (run_bus.rs),
        .i_run_e     (run_bus.e),
        .i_run_d     (run_bus.d),
        .o_rs        (lcd_bus.rs),
        .o_e         (lcd_bus.e),
        .o_d         (lcd_bus.d),
        .o_ready     (ready),
        .o_run_reset (run_reset)
    );

    always #5 clk = ~clk;

`ifdef HD44780_TWO_LINE_EN
    localparam logic [7:0] EXP_FSET = 8'h38;
`else
    localparam logic [7:0] EXP_FSET = 8'h30;
`endif

    logic [7:0] exp_b [8];
    int         exp_t [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input bit en);
        ena = en;
        @(posedge clk);
        #1;
    endtask

    // Full sequence from S_POR with i_ena high every div-th clock.
    task automatic run_seq(input int div);
        int         ticks  = 0;
        int         clks   = 0;
        int         npulse = 0;
        int         rs_bad = 0;
        logic       pe     = 1'b0;
        logic [7:0] got_b [8];
        int         got_t [8];
        bit         en;
        for (int k = 0; k < 8; k++) begin
            got_b[k] = 8'hFF;
            got_t[k] = -1;
        end
        while (clks < 400) begin
            clks++;
            en = ((clks % div) == 0);
            tick(en);
            if (en) ticks++;
            if (clks == 1) chk("por_d_blocked", lcd_bus.d, 8'h00);
            if (ready) break;
            if (lcd_bus.rs) rs_bad++;
            if (lcd_bus.e && !pe) begin
                if (npulse < 8) begin
                    got_b[npulse] = lcd_bus.d;
                    got_t[npulse] = clks;
                end
                npulse++;
            end
            pe = lcd_bus.e;
        end
        chk("ready_seen", ready, 1);
        chk("ready_ticks", ticks, 39);
        chk("ready_clks", clks, 39 * div);
        chk("pulse_count", npulse, 8);
        chk("rs_low_in_init", rs_bad, 0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("byte%0d", k), got_b[k], exp_b[k]);
            chk($sformatf("time%0d", k), got_t[k], exp_t[k] * div);
        end
    endtask

    initial begin
        int  extra;
        bit  found;
        exp_b = '{8'h30, 8'h30, 8'h30, EXP_FSET, 8'h08, 8'h01, 8'h06, 8'h0C};
        exp_t = '{5, 9, 13, 17, 21, 25, 32, 36};

        rst        = 1'b1;
        ena        = 1'b1;
        reinit     = 1'b0;
        run_bus.rs = 1'b1;
        run_bus.e  = 1'b1;
        run_bus.d  = 8'hA5;
        repeat (2) tick(1);
        chk("rst_e", lcd_bus.e, 0);
        chk("rst_d", lcd_bus.d, 8'h00);
        chk("rst_rs", lcd_bus.rs, 0);
        chk("rst_ready", ready, 0);
        chk("rst_run_reset", run_reset, 1);

        rst = 1'b0;
        run_seq(1);

        // Bypass is combinational in S_RUN
        chk("run_d", lcd_bus.d, 8'hA5);
        chk("run_rs", lcd_bus.rs, 1);
        chk("run_e", lcd_bus.e, 1);
        chk("run_run_reset", run_reset, 0);
        run_bus.rs = 1'b0;
        run_bus.e  = 1'b0;
        run_bus.d  = 8'h5A;
        #1;
        chk("run_d_same_cycle", lcd_bus.d, 8'h5A);
        chk("run_e_same_cycle", lcd_bus.e, 0);

        reinit = 1'b1;
        tick(1);
        reinit = 1'b0;
        chk("reinit_ready", ready, 0);
        chk("reinit_run_reset", run_reset, 1);
        chk("reinit_e", lcd_bus.e, 0);
        chk("reinit_d", lcd_bus.d, 8'h30);
        tick(1);
        chk("reinit_pulse_e", lcd_bus.e, 1);
        chk("reinit_pulse_d", lcd_bus.d, 8'h30);
        tick(1);
        reinit = 1'b1;
        tick(1);
        reinit = 1'b0;
        chk("wait_reinit_ready", ready, 0);
        chk("wait_reinit_d", lcd_bus.d, 8'h30);
        extra = 3;
        while (!ready && extra < 200) begin
            tick(1);
            extra++;
        end
        chk("reinit_ticks", extra, 35);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (lcd_bus.e && lcd_bus.d == 8'h01) begin
                found = 1'b1;
                break;
            end
        end
        chk("clear_pulse_found", found, 1);
        rst    = 1'b1;
        reinit = 1'b1;
        tick(1);
        rst    = 1'b0;
        reinit = 1'b0;
        chk("midrst_e", lcd_bus.e, 0);
        chk("midrst_d", lcd_bus.d, 8'h00);
        chk("midrst_ready", ready, 0);
        chk("midrst_run_reset", run_reset, 1);
        run_bus.rs = 1'b1;
        run_bus.e  = 1'b1;
        run_bus.d  = 8'hA5;
        run_seq(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
